// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_EXT  = 2'b10
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W_DEF        = 3;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating count of consecutive denied external cycles. Raises force_ext when
// the limit is reached, so the arbiter hands the next slot to the external side.
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic force_ext,
  output logic starved
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             starved_d, starved_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    starved_d = (cnt_d != '0);
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      starved_q <= starved_d;
    end
  end

  assign force_ext = (cnt_q == LIMIT);
  assign starved   = starved_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the core (fixed priority) and an
// external host/DMA agent, and steers one-cycle read data back to its owner.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DMA_SIZE     = 16,
  parameter int unsigned DMD_SIZE     = 16,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic                core_wrb,
  input  logic [DMA_SIZE-1:0] core_add,
  input  logic [DMD_SIZE-1:0] core_wdt,
  output logic                core_stall,
  output logic                core_rvld,
  output logic [DMD_SIZE-1:0] core_rdt,
  input  logic                ext_req,
  input  logic                ext_wrb,
  input  logic [DMA_SIZE-1:0] ext_add,
  input  logic [DMD_SIZE-1:0] ext_wdt,
  output logic                ext_gnt,
  output logic                ext_rvld,
  output logic [DMD_SIZE-1:0] ext_rdt,
  output logic                mem_cslt,
  output logic                mem_wrb,
  output logic [DMA_SIZE-1:0] mem_add,
  output logic [DMD_SIZE-1:0] mem_wdt,
  input  logic [DMD_SIZE-1:0] mem_rdt,
  output logic                ext_starved
);

  owner_e own;
  logic   force_ext;
  logic   rd_core_d, rd_core_q;
  logic   rd_ext_d, rd_ext_q;

  dm_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (ext_gnt || !ext_req),
    .inc       (ext_req && !ext_gnt),
    .force_ext (force_ext),
    .starved   (ext_starved)
  );

  // Grant is resolved in the same cycle; everything stays quiet while reset is held.
  always_comb begin
    own = OWN_NONE;
    if (reset) begin
      unique case ({core_req, ext_req})
        2'b10:   own = OWN_CORE;
        2'b01:   own = OWN_EXT;
        2'b11:   own = force_ext ? OWN_EXT : OWN_CORE;
        default: own = OWN_NONE;
      endcase
    end
  end

  always_comb begin
    mem_cslt   = 1'b0;
    mem_wrb    = 1'b0;
    mem_add    = '0;
    mem_wdt    = '0;
    ext_gnt    = 1'b0;
    core_stall = 1'b0;
    unique case (own)
      OWN_CORE: begin
        mem_cslt = 1'b1;
        mem_wrb  = core_wrb;
        mem_add  = core_add;
        mem_wdt  = core_wdt;
      end
      OWN_EXT: begin
        mem_cslt   = 1'b1;
        mem_wrb    = ext_wrb;
        mem_add    = ext_add;
        mem_wdt    = ext_wdt;
        ext_gnt    = 1'b1;
        core_stall = core_req;
      end
      default: ;
    endcase
  end

  // Remember who owns the read launched this cycle so next cycle's data goes back to them.
  always_comb begin
    rd_core_d = (own == OWN_CORE) && !core_wrb;
    rd_ext_d  = (own == OWN_EXT)  && !ext_wrb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_core_q <= 1'b0;
      rd_ext_q  <= 1'b0;
    end else begin
      rd_core_q <= rd_core_d;
      rd_ext_q  <= rd_ext_d;
    end
  end

  assign core_rvld = rd_core_q;
  assign ext_rvld  = rd_ext_q;
  assign core_rdt  = rd_core_q ? mem_rdt : '0;
  assign ext_rdt   = rd_ext_q  ? mem_rdt : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: read returns are checked by a scoreboard
// monitor, per-cycle grant/mux behaviour is checked directly.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  typedef struct {
    owner_e      own;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_wrb;
  logic [15:0] core_add, core_wdt;
  logic        core_stall, core_rvld;
  logic [15:0] core_rdt;
  logic        ext_req, ext_wrb;
  logic [15:0] ext_add, ext_wdt;
  logic        ext_gnt, ext_rvld;
  logic [15:0] ext_rdt;
  logic        mem_cslt, mem_wrb;
  logic [15:0] mem_add, mem_wdt;
  logic [15:0] mem_rdt;
  logic        ext_starved;

  logic [15:0] mem [0:65535];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_wrb    (core_wrb),
    .core_add    (core_add),
    .core_wdt    (core_wdt),
    .core_stall  (core_stall),
    .core_rvld   (core_rvld),
    .core_rdt    (core_rdt),
    .ext_req     (ext_req),
    .ext_wrb     (ext_wrb),
    .ext_add     (ext_add),
    .ext_wdt     (ext_wdt),
    .ext_gnt     (ext_gnt),
    .ext_rvld    (ext_rvld),
    .ext_rdt     (ext_rdt),
    .mem_cslt    (mem_cslt),
    .mem_wrb     (mem_wrb),
    .mem_add     (mem_add),
    .mem_wdt     (mem_wdt),
    .mem_rdt     (mem_rdt),
    .ext_starved (ext_starved)
  );

  // Synchronous data memory with one-cycle read latency; content preloaded as addr ^ 0xA5A5.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem_rdt = '0;
  end

  always @(posedge clk) begin
    if (mem_cslt) begin
      if (mem_wrb) mem[mem_add] <= mem_wdt;
      else         mem_rdt <= mem[mem_add];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic pop_cmp(input owner_e o, input logic [15:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: owner %0d data 0x%0h with no pending read at %0t", o, d, $time);
    end else begin
      e = sb_q.pop_front();
      check("rd_owner", 32'(o), 32'(e.own));
      check("rd_data", 32'(d), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (core_rvld) pop_cmp(OWN_CORE, core_rdt);
    if (ext_rvld)  pop_cmp(OWN_EXT, ext_rdt);
  end

  task automatic push_exp(input owner_e o, input logic [15:0] d);
    exp_t e;
    e.own  = o;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                      input logic er, input logic ew, input logic [15:0] ea, input logic [15:0] ed);
    @(posedge clk);
    #1;
    core_req = cr; core_wrb = cw; core_add = ca; core_wdt = cd;
    ext_req  = er; ext_wrb  = ew; ext_add  = ea; ext_wdt  = ed;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    reset    = 1'b0;
    core_req = 1'b1; core_wrb = 1'b0; core_add = 16'h0010; core_wdt = 16'h1111;
    ext_req  = 1'b1; ext_wrb  = 1'b1; ext_add  = 16'h0050; ext_wdt  = 16'h2222;

    // Reset held with both requesting: everything quiet.
    @(negedge clk);
    @(negedge clk);
    check("rst_core_stall", core_stall, 0);
    check("rst_ext_gnt", ext_gnt, 0);
    check("rst_mem_cslt", mem_cslt, 0);
    check("rst_mem_wrb", mem_wrb, 0);
    check("rst_mem_add", mem_add, 0);
    check("rst_mem_wdt", mem_wdt, 0);
    check("rst_core_rvld", core_rvld, 0);
    check("rst_ext_rvld", ext_rvld, 0);
    check("rst_core_rdt", core_rdt, 0);
    check("rst_ext_rdt", ext_rdt, 0);
    check("rst_starved", ext_starved, 0);

    // Release: core wins the first contested cycle.
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_mem_cslt", mem_cslt, 1);
    check("rel_mem_add", mem_add, 16'h0010);
    check("rel_mem_wrb", mem_wrb, 0);
    check("rel_ext_gnt", ext_gnt, 0);
    check("rel_core_stall", core_stall, 0);
    push_exp(OWN_CORE, 16'hA5B5);
    idle();
    check("rel_starved", ext_starved, 1);
    check("idle_mem_cslt", mem_cslt, 0);
    check("idle_mem_add", mem_add, 0);

    // Core write then read back.
    step(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);
    check("wr_mem_cslt", mem_cslt, 1);
    check("wr_mem_wrb", mem_wrb, 1);
    check("wr_mem_add", mem_add, 16'h0020);
    check("wr_mem_wdt", mem_wdt, 16'hBEEF);
    check("wr_starved", ext_starved, 0);
    step(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("rd_mem_wrb", mem_wrb, 0);
    push_exp(OWN_CORE, 16'hBEEF);
    idle();

    // External only.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0);
    check("ext_gnt_solo", ext_gnt, 1);
    check("ext_stall_solo", core_stall, 0);
    check("ext_mem_add", mem_add, 16'h0005);
    push_exp(OWN_EXT, 16'hA5A0);
    idle();

    // Continuous contention: forced external slot every 5th cycle.
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234);
      check($sformatf("starve_gnt_%0d", k), ext_gnt, (k % 5 == 0) ? 1 : 0);
      check($sformatf("starve_stall_%0d", k), core_stall, (k % 5 == 0) ? 1 : 0);
      check($sformatf("starve_flag_%0d", k), ext_starved, (((k - 1) % 5) != 0) ? 1 : 0);
      if (k % 5 == 0) begin
        check($sformatf("starve_add_%0d", k), mem_add, 16'h0040);
        check($sformatf("starve_wrb_%0d", k), mem_wrb, 1);
      end else begin
        push_exp(OWN_CORE, 16'hA595);
      end
    end
    idle();

    // Alternating owners: core reads, then forced external read, then core again.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
      if (k < 5) push_exp(OWN_CORE, 16'hA5A4);
      else begin
        check("alt_ext_gnt", ext_gnt, 1);
        push_exp(OWN_EXT, 16'hA5A7);
      end
    end
    step(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("alt_core_after", core_stall, 0);
    push_exp(OWN_CORE, 16'hA5A4);
    idle();

    // Reset right after a core read grant drops the pending read.
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0060, 16'h7777);
    check("mid_ext_gnt", ext_gnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    core_req = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    check("mid_rst_rvld", core_rvld, 0);
    check("mid_rst_starved", ext_starved, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rel_rvld", core_rvld, 0);
    check("mid_rel_starved", ext_starved, 0);
    idle();
    idle();
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
